// File: rtl/fp_conv_ctrl.sv
// rtl/fp_conv_ctrl.sv - two's-complement to packed {S,E,F} float sequencer
// Optional out_sat saturation flag port: define FP_CONV_SAT_FLAG_EN.
module fp_conv_ctrl #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [SIG_W-1:0] out_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef FP_CONV_SAT_FLAG_EN
  ,
  output logic             out_sat
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [EXP_W:0]  CNT_MAX  = {1'b1, {EXP_W{1'b0}}};
  localparam logic [EXP_W-1:0] E_MAX   = {EXP_W{1'b1}};
  localparam logic [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] MAG_MAX  = {1'b0, {(IN_W-1){1'b1}}};

  logic [1:0]       state_q, state_d;
  logic             s_q, s_d;
  logic [IN_W-1:0]  sh_q, sh_d;
  logic [EXP_W:0]   cnt_q, cnt_d;
  logic             out_s_q, out_s_d;
  logic [EXP_W-1:0] out_e_q, out_e_d;
  logic [SIG_W-1:0] out_f_q, out_f_d;

  logic [IN_W-1:0]  mag;
  logic [SIG_W-1:0] f0;
  logic             rbit;
  logic [SIG_W:0]   f_inc;
  logic [EXP_W:0]   e_w;
  logic [EXP_W-1:0] rnd_e;
  logic [SIG_W-1:0] rnd_f;
`ifdef FP_CONV_SAT_FLAG_EN
  logic             sat_q, sat_d, rnd_sat;
`endif

  // Negating the most-negative code overflows back onto itself, so clamp it.
  always_comb begin
    if (!in_data[IN_W-1])
      mag = in_data;
    else if (in_data == MOST_NEG)
      mag = MAG_MAX;
    else
      mag = ~in_data + 1'b1;
  end

  always_comb begin
    f0    = sh_q[IN_W-1 -: SIG_W];
    rbit  = sh_q[IN_W-1-SIG_W];
    f_inc = {1'b0, f0} + 1'b1;
    e_w   = CNT_MAX - cnt_q;
    rnd_e = '0;
    rnd_f = f0;
`ifdef FP_CONV_SAT_FLAG_EN
    rnd_sat = 1'b0;
`endif
    if (cnt_q != CNT_MAX) begin
      rnd_e = e_w[EXP_W-1:0];
      if (rbit) begin
        if (!f_inc[SIG_W]) begin
          rnd_f = f_inc[SIG_W-1:0];
        end else if (e_w[EXP_W-1:0] == E_MAX) begin
          rnd_e = E_MAX;
          rnd_f = '1;
`ifdef FP_CONV_SAT_FLAG_EN
          rnd_sat = 1'b1;
`endif
        end else begin
          rnd_e = e_w[EXP_W-1:0] + 1'b1;
          rnd_f = {1'b1, {(SIG_W-1){1'b0}}};
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    out_s_d = out_s_q;
    out_e_d = out_e_q;
    out_f_d = out_f_q;
`ifdef FP_CONV_SAT_FLAG_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_data[IN_W-1];
          sh_d    = {1'b0, mag[IN_W-2:0]};
          cnt_d   = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (sh_q[IN_W-1] || (cnt_q == CNT_MAX)) begin
          state_d = ROUND;
        end else begin
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ROUND: begin
        out_s_d = s_q;
        out_e_d = rnd_e;
        out_f_d = rnd_f;
`ifdef FP_CONV_SAT_FLAG_EN
        sat_d   = rnd_sat;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_s_q <= 1'b0;
      out_e_q <= '0;
      out_f_q <= '0;
`ifdef FP_CONV_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      out_s_q <= out_s_d;
      out_e_q <= out_e_d;
      out_f_q <= out_f_d;
`ifdef FP_CONV_SAT_FLAG_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_s     = out_s_q;
  assign out_e     = out_e_q;
  assign out_f     = out_f_q;
`ifdef FP_CONV_SAT_FLAG_EN
  assign out_sat   = sat_q;
`endif

endmodule

// File: tb/tb_fp_conv_ctrl.sv
// tb/tb_fp_conv_ctrl.sv - directed self-checking bench for fp_conv_ctrl
// Checks out_sat too when FP_CONV_SAT_FLAG_EN is defined.
module tb_fp_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef FP_CONV_SAT_FLAG_EN
  logic        out_sat;
`endif

  int vectors = 0;
  int miscompares = 0;

  fp_conv_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef FP_CONV_SAT_FLAG_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion built from leading-zero count rather than a shifter.
  function automatic logic [7:0] model(input logic [11:0] d);
    int m, lz, e, f;
    logic [11:0] n;
    if (!d[11]) m = int'(d);
    else if (d == 12'h800) m = 2047;
    else m = 4096 - int'(d);
    lz = 0;
    while (lz < 8 && ((m & (1 << (11 - lz))) == 0)) lz++;
    if (lz == 8) begin
      e = 0;
      f = m & 15;
    end else begin
      n = 12'(m << lz);
      f = int'(n[11:8]);
      e = 8 - lz;
      if (n[7]) begin
        f++;
        if (f == 16) begin
          f = 8;
          e++;
          if (e == 8) begin
            e = 7;
            f = 15;
          end
        end
      end
    end
    return {d[11], 3'(e), 4'(f)};
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic convert(input string tag, input logic [11:0] d, input logic es,
                         input logic [2:0] ee, input logic [3:0] ef, input int el,
                         input logic esat);
    int lat;
    chk({tag, ".in_ready_pre"}, 16'(in_ready), 16'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 12'(~d);
    chk({tag, ".busy"}, 16'(busy), 16'd1);
    wait_valid(lat);
    chk({tag, ".latency"}, 16'(lat), 16'(el));
    chk({tag, ".sef"}, {8'd0, out_s, out_e, out_f}, {8'd0, es, ee, ef});
`ifdef FP_CONV_SAT_FLAG_EN
    chk({tag, ".sat"}, 16'(out_sat), 16'(esat));
`else
    if (esat) chk({tag, ".in_ready_done"}, 16'(in_ready), 16'd0);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".post_hs"}, {14'd0, out_valid, in_ready}, 16'b01);
    chk({tag, ".held"}, {8'd0, out_s, out_e, out_f}, {8'd0, es, ee, ef});
  endtask

  logic [11:0] smp [8];
  logic [7:0]  exp_v;
  int lat, ni, no, cyc, extra;
  logic acc;

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {10'd0, in_ready, busy, out_valid, out_s, out_e == 3'd0, out_f == 4'd0},
        {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    convert("zero",  12'h000, 1'b0, 3'd0, 4'd0,  10, 1'b0);
    convert("p422",  12'd422, 1'b0, 3'd5, 4'd13, 5,  1'b0);
    convert("n422",  12'hE5A, 1'b1, 3'd5, 4'd13, 5,  1'b0);
    convert("p63",   12'd63,  1'b0, 3'd3, 4'd8,  8,  1'b0);
    convert("p7ff",  12'h7FF, 1'b0, 3'd7, 4'd15, 3,  1'b1);
    convert("n800",  12'h800, 1'b1, 3'd7, 4'd15, 3,  1'b1);
    convert("p00b",  12'h00B, 1'b0, 3'd0, 4'd11, 10, 1'b0);
    convert("p010",  12'h010, 1'b0, 3'd1, 4'd8,  9,  1'b0);

    // Output backpressure with a competing sample offered during DONE.
    in_data = 12'd422; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 12'd63;
    wait_valid(lat);
    chk("bp.latency", 16'(lat), 16'd5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.stable", {7'd0, out_valid, in_ready, out_s, out_e, out_f},
          {7'd0, 1'b1, 1'b0, 1'b0, 3'd5, 4'd13});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp.no_accept_at_hs", {14'd0, in_ready, busy}, 16'b10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp.accept_next", 16'(busy), 16'd1);
    wait_valid(lat);
    chk("bp.second_latency", 16'(lat), 16'd8);
    chk("bp.second_sef", {8'd0, out_s, out_e, out_f}, {8'd0, 1'b0, 3'd3, 4'd8});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of normalisation.
    in_data = 12'h000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst", {9'd0, out_valid, in_ready, busy, out_s, out_e == 3'd0, out_f == 4'd0, 1'b0},
        {9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.no_result", 16'(out_valid), 16'd0);
    convert("after_rst", 12'hE5A, 1'b1, 3'd5, 4'd13, 5, 1'b0);

    // Back-to-back stream against the reference model.
    smp[0] = 12'h800; smp[1] = 12'h001; smp[2] = 12'd63; smp[3] = 12'hFFF;
    for (int i = 4; i < 8; i++) smp[i] = 12'($urandom_range(0, 4095));
    ni = 0; no = 0; cyc = 0;
    in_data = smp[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (no < 8 && cyc < 2000) begin
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        ni++;
        if (ni < 8) in_data = smp[ni];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        exp_v = model(smp[no]);
        chk($sformatf("stream[%0d]", no), {8'd0, out_s, out_e, out_f}, {8'd0, exp_v});
        no++;
      end
    end
    chk("stream.count", 16'(no), 16'd8);
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    chk("stream.no_dup", 16'(extra), 16'd0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
